// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1:4 demultiplexer.
// Used by demux_slot and demux_1_4_reg.
package demux_pkg;

   localparam int N_OUT = 4;

   typedef logic [1:0] demux_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output lane.
// A load in the same cycle as a drain keeps the slot full with the new beat.
module demux_slot #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         drain,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      valid_d = valid_q & ~drain;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/demux_1_4_reg.sv
// Registered 1:4 valid/ready demultiplexer with one holding slot per lane.
// Define DEMUX_ROUND_ROBIN_EN to target lanes by a rotating pointer instead of sel.
module demux_1_4_reg
   import demux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   input  logic [1:0]     sel,
   output logic [3:0]     out_valid,
   input  logic [3:0]     out_ready,
   output logic [4*W-1:0] out_data
);

   demux_sel_t       tgt;
   logic             accept;
   logic [N_OUT-1:0] load;

`ifdef DEMUX_ROUND_ROBIN_EN
   demux_sel_t rr_ptr_q;
   demux_sel_t rr_ptr_d;
   logic       unused_sel;

   assign unused_sel = ^sel;
   assign tgt        = rr_ptr_q;

   // Pointer only moves on an accepted beat, so a stall retries the same lane
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) rr_ptr_d = rr_ptr_q + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= '0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`else
   assign tgt = sel;
`endif

   assign in_ready = ~out_valid[tgt] | out_ready[tgt];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load      = '0;
      load[tgt] = accept;
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      demux_slot #(.W(W)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[k]),
         .load_data (in_data),
         .drain     (out_valid[k] & out_ready[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*W +: W])
      );
   end

endmodule
